// File: rtl/unidad_busqueda.sv
// Instruction-fetch stage: holds the PC, feeds the external Sumador for PC+4,
// fetches over req/ack and hands each instruction plus its PC to decode.
module unidad_busqueda #(
    parameter int unsigned      ANCHO    = 32,
    parameter logic [ANCHO-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [ANCHO-1:0] suma_A,
    output logic [ANCHO-1:0] suma_B,
    input  logic [ANCHO-1:0] suma_O,
    input  logic             salto_valido,
    input  logic [ANCHO-1:0] salto_destino,
    output logic             mem_req,
    output logic [ANCHO-1:0] mem_dir,
    input  logic             mem_ack,
    input  logic [ANCHO-1:0] mem_dato,
    output logic [ANCHO-1:0] instr,
    output logic [ANCHO-1:0] instr_pc,
    output logic             instr_valida,
    input  logic             dec_listo,
    output logic [ANCHO-1:0] cuenta_instr
);

    typedef enum logic {
        BUSCA   = 1'b0,
        ENTREGA = 1'b1
    } estado_t;

    estado_t          r_estado;
    logic [ANCHO-1:0] r_pc;
    logic [ANCHO-1:0] r_instr;
    logic [ANCHO-1:0] r_instr_pc;
    logic [ANCHO-1:0] r_cuenta;
    logic [ANCHO-1:0] w_destino;

    // Redirect targets are forced to word alignment; the low two bits are dropped.
    assign w_destino = salto_destino & ~ANCHO'(3);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado   <= BUSCA;
            r_pc       <= PC_RESET;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_cuenta   <= '0;
        end else begin
            case (r_estado)
                BUSCA: begin
                    if (salto_valido) begin
                        r_pc <= w_destino;
                    end else if (mem_ack) begin
                        r_instr    <= mem_dato;
                        r_instr_pc <= r_pc;
                        r_pc       <= suma_O;
                        r_estado   <= ENTREGA;
                    end
                end
                ENTREGA: begin
                    // A handshake coinciding with a redirect still counts.
                    if (dec_listo) begin
                        r_cuenta <= r_cuenta + ANCHO'(1);
                    end
                    if (salto_valido) begin
                        r_pc     <= w_destino;
                        r_estado <= BUSCA;
                    end else if (dec_listo) begin
                        r_estado <= BUSCA;
                    end
                end
                default: r_estado <= BUSCA;
            endcase
        end
    end

    assign suma_A       = r_pc;
    assign suma_B       = ANCHO'(4);
    assign mem_dir      = r_pc;
    assign mem_req      = (r_estado == BUSCA) & ~reset;
    assign instr_valida = (r_estado == ENTREGA) & ~reset;
    assign instr        = r_instr;
    assign instr_pc     = r_instr_pc;
    assign cuenta_instr = r_cuenta;

endmodule

// File: tb/tb_unidad_busqueda.sv
// Directed plus randomized bench for unidad_busqueda against a transaction-level
// fetch model; the Sumador is modelled as a plain PC+4 adder.
module tb_unidad_busqueda;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] suma_A, suma_B, suma_O;
    logic        salto_valido;
    logic [31:0] salto_destino;
    logic        mem_req;
    logic [31:0] mem_dir;
    logic        mem_ack;
    logic [31:0] mem_dato;
    logic [31:0] instr, instr_pc;
    logic        instr_valida;
    logic        dec_listo;
    logic [31:0] cuenta_instr;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: PC, whether an instruction is being offered, and what was offered.
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
    bit          m_ofrece;

    always #5 clk = ~clk;

    assign suma_O = suma_A + 32'd4;

    unidad_busqueda #(.ANCHO(32), .PC_RESET(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .suma_A(suma_A), .suma_B(suma_B), .suma_O(suma_O),
        .salto_valido(salto_valido), .salto_destino(salto_destino),
        .mem_req(mem_req), .mem_dir(mem_dir), .mem_ack(mem_ack), .mem_dato(mem_dato),
        .instr(instr), .instr_pc(instr_pc), .instr_valida(instr_valida),
        .dec_listo(dec_listo), .cuenta_instr(cuenta_instr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs against the model, then advance both.
    task automatic ciclo(input bit r, input bit sv, input logic [31:0] sd, input bit ack,
                         input logic [31:0] dato, input bit listo, input bit comprobar);
        reset = r; salto_valido = sv; salto_destino = sd;
        mem_ack = ack; mem_dato = dato; dec_listo = listo;
        #1;
        if (comprobar) begin
            chk("mem_req",      {31'd0, mem_req},      {31'd0, !m_ofrece && !r});
            chk("instr_valida", {31'd0, instr_valida}, {31'd0, m_ofrece && !r});
            chk("mem_dir",      mem_dir,      m_pc);
            chk("suma_A",       suma_A,       m_pc);
            chk("suma_B",       suma_B,       32'd4);
            chk("instr",        instr,        m_instr);
            chk("instr_pc",     instr_pc,     m_ipc);
            chk("cuenta_instr", cuenta_instr, m_cnt);
        end
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_ofrece = 0; m_cnt = 0; m_instr = 0; m_ipc = 0;
        end else if (!m_ofrece) begin
            if (sv) m_pc = {sd[31:2], 2'b00};
            else if (ack) begin
                m_instr = dato; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_ofrece = 1;
            end
        end else begin
            if (listo) m_cnt = m_cnt + 32'd1;
            if (sv) begin
                m_pc = {sd[31:2], 2'b00}; m_ofrece = 0;
            end else if (listo) m_ofrece = 0;
        end
        #1;
    endtask

    task automatic reinicio();
        ciclo(1, 0, 0, 0, 0, 0, 1);
        ciclo(1, 0, 0, 1, 32'hDEAD_BEEF, 1, 1);
    endtask

    initial begin
        m_pc = 0; m_ofrece = 0; m_cnt = 0; m_instr = 0; m_ipc = 0;

        // Reset held two cycles, then first free cycle requests PC_RESET
        ciclo(1, 0, 0, 0, 0, 0, 0);
        ciclo(1, 0, 0, 0, 0, 0, 1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_valida",  {31'd0, instr_valida}, 32'd0);
        reset = 1'b0; #1;
        chk("rel_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rel_mem_dir", mem_dir, 32'h0);

        // Sequential fetch with decode always ready
        for (int i = 0; i < 8; i++)
            ciclo(0, 0, 0, 1, 32'hA000_0000 + m_pc, 1, 1);
        chk("seq_cuenta",   cuenta_instr, 32'd4);
        chk("seq_instr_pc", instr_pc, 32'd12);
        chk("seq_instr",    instr, 32'hA000_000C);
        chk("seq_mem_dir",  mem_dir, 32'd16);

        // Decode stall after the first instruction
        reinicio();
        ciclo(0, 0, 0, 1, 32'hA000_0000, 0, 1);
        for (int i = 0; i < 5; i++) begin
            ciclo(0, 0, 0, (i % 2) == 0, 32'h1234_5678, 0, 1);
            chk("stall_pc",    instr_pc, 32'h0);
            chk("stall_instr", instr, 32'hA000_0000);
        end
        ciclo(0, 0, 0, 0, 0, 1, 1);
        chk("stall_next_dir", mem_dir, 32'd4);

        // Redirect collides with ack in BUSCA: data dropped
        ciclo(0, 1, 32'h0000_0103, 1, 32'hBAD0_BAD0, 0, 1);
        chk("col_dir",    mem_dir, 32'h0000_0100);
        chk("col_valida", {31'd0, instr_valida}, 32'd0);
        // Redirect during ENTREGA with handshake
        ciclo(0, 0, 0, 1, 32'hC0DE_0100, 0, 1);
        ciclo(0, 1, 32'h0000_0202, 0, 0, 1, 1);
        chk("entr_sv_cnt", cuenta_instr, 32'd2);
        chk("entr_sv_dir", mem_dir, 32'h0000_0200);

        // Wrap-around through the adder
        ciclo(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 1);
        ciclo(0, 0, 0, 1, 32'h5555_AAAA, 0, 1);
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_dir", mem_dir, 32'h0);
        ciclo(0, 0, 0, 0, 0, 1, 1);

        // Redirect held several cycles
        for (int i = 0; i < 3; i++)
            ciclo(0, 1, 32'h0000_0040 + 32'(i * 8), 1, 32'h1, 0, 1);
        chk("held_dir", mem_dir, 32'h0000_0050);

        // Reset in ENTREGA with three completed handshakes while ack pulses
        reinicio();
        for (int i = 0; i < 6; i++)
            ciclo(0, 0, 0, 1, 32'h7000_0000 + m_pc, 1, 1);
        ciclo(0, 0, 0, 1, 32'h7700_0000, 0, 1);
        chk("mid_cnt3", cuenta_instr, 32'd3);
        ciclo(1, 0, 0, 1, 32'hFFFF_0000, 1, 1);
        chk("mid_cnt0",   cuenta_instr, 32'd0);
        chk("mid_dir",    mem_dir, 32'h0);
        chk("mid_valida", {31'd0, instr_valida}, 32'd0);
        chk("mid_instr",  instr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            automatic logic [31:0] sd  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(15)
                                                                   : $urandom;
            automatic bit          r   = ($urandom_range(63) == 0);
            automatic bit          sv  = ($urandom_range(5) == 0);
            automatic bit          ack = $urandom_range(1) == 1;
            automatic bit          lst = $urandom_range(1) == 1;
            ciclo(r, sv, sd, ack, $urandom, lst, 1);
        end
        ciclo(0, 0, 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
